// File: rtl/mips_ctrl_pkg.sv
// Shared constants, state encoding and per-state strobe decode for the
// multi-cycle MIPS main controller.
package mips_ctrl_pkg;

   // Opcodes (instruction[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   // R-type funct codes the datapath ALU implements
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU operation select
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   // ALU B-operand select
   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_FETCH     = 4'd1,
      ST_DECODE    = 4'd2,
      ST_R_EXEC    = 4'd3,
      ST_R_WB      = 4'd4,
      ST_MEM_ADDR  = 4'd5,
      ST_MEM_READ  = 4'd6,
      ST_MEM_WB    = 4'd7,
      ST_MEM_WRITE = 4'd8,
      ST_BRANCH    = 4'd9,
      ST_JUMP      = 4'd10,
      ST_I_EXEC    = 4'd11,
      ST_I_WB      = 4'd12,
      ST_TRAP      = 4'd13
   } state_e;

   // Strobes held per state; *_rdy fields are later qualified by mem_ready.
   typedef struct packed {
      logic       ir_wr_rdy;
      logic       pc_wr;
      logic       pc_wr_rdy;
      logic       pc_wr_cond;
      logic       ior_d;
      logic       mem_rd;
      logic       mem_wr;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_wr;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       retire;
      logic       retire_rdy;
   } ctrl_t;

   function automatic logic funct_legal(input logic [5:0] fn);
      logic ok;
      case (fn)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
         default:                               ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Strobe pattern for a state; ori selects the OR ALU op in I_EXEC.
   function automatic ctrl_t ctrl_for_state(input state_e st, input logic ori);
      ctrl_t c;
      c = ctrl_t'({$bits(ctrl_t){1'b0}});
      case (st)
         ST_FETCH: begin
            c.ir_wr_rdy = 1'b1;
            c.pc_wr_rdy = 1'b1;
            c.mem_rd    = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALUOP_ADD;
            c.pc_source = PCSRC_ALU;
         end
         ST_DECODE: begin
            c.alu_src_b = SRCB_IMM_SH2;
            c.alu_op    = ALUOP_ADD;
         end
         ST_R_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_RT;
            c.alu_op    = ALUOP_FUNCT;
         end
         ST_R_WB: begin
            c.reg_dst = 1'b1;
            c.reg_wr  = 1'b1;
            c.retire  = 1'b1;
         end
         ST_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         ST_MEM_READ: begin
            c.ior_d  = 1'b1;
            c.mem_rd = 1'b1;
         end
         ST_MEM_WB: begin
            c.reg_wr     = 1'b1;
            c.mem_to_reg = 1'b1;
            c.retire     = 1'b1;
         end
         ST_MEM_WRITE: begin
            c.ior_d      = 1'b1;
            c.mem_wr     = 1'b1;
            c.retire_rdy = 1'b1;
         end
         ST_BRANCH: begin
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = SRCB_RT;
            c.alu_op     = ALUOP_SUB;
            c.pc_wr_cond = 1'b1;
            c.pc_source  = PCSRC_ALUOUT;
            c.retire     = 1'b1;
         end
         ST_JUMP: begin
            c.pc_wr     = 1'b1;
            c.pc_source = PCSRC_JUMP;
            c.retire    = 1'b1;
         end
         ST_I_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ori ? ALUOP_OR : ALUOP_ADD;
         end
         ST_I_WB: begin
            c.reg_wr = 1'b1;
            c.retire = 1'b1;
         end
         default: begin
            c = ctrl_t'({$bits(ctrl_t){1'b0}});
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on a memory access and flags when the
// MEM_TIMEOUT-th waiting cycle is reached.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 64
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   // Count value during the final allowed wait cycle.
   localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

   logic [7:0] count_q;

   // Wait-cycle counter: cleared between accesses, saturates at the limit
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= 8'd0;
      end else if (clear_i) begin
         count_q <= 8'd0;
      end else if (enable_i && !expired_o) begin
         count_q <= count_q + 8'd1;
      end else begin
         count_q <= count_q;
      end
   end

   assign expired_o = (count_q >= LIMIT);

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/
// writeback, flags illegal instructions and memory timeouts, counts retires.
module mips_multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             irWrite,
   output logic             pcWrite,
   output logic             pcWriteCond,
   output logic             iorD,
   output logic             memRead,
   output logic             memWrite,
   output logic             memToReg,
   output logic             regDst,
   output logic             regWr,
   output logic             aluSrcA,
   output logic [1:0]       aluSrcB,
   output logic [1:0]       aluOp,
   output logic [1:0]       pcSource,
   output logic             retire,
   output logic [CNT_W-1:0] instr_count,
   output logic             trap,
   output logic             bus_error
);

   state_e           state_q, state_d;
   ctrl_t            ctrl_q;
   logic             is_sw_q, is_sw_d;
   logic             is_ori_q, is_ori_d;
   logic             trap_q, bus_error_q;
   logic [CNT_W-1:0] count_q;
   logic             in_mem_s, expired_s, timeout_s, gate_s, retire_s;
   logic             unused_s;

   // zero only gates the PC write in the datapath (pcWriteCond & zero).
   assign unused_s = zero;

   assign in_mem_s = (state_q == ST_FETCH) || (state_q == ST_MEM_READ) ||
                     (state_q == ST_MEM_WRITE);

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk_i     (clock),
      .rst_i     (reset),
      .clear_i   (~in_mem_s | mem_ready),
      .enable_i  (in_mem_s),
      .expired_o (expired_s)
   );

   // Next-state selection and capture of instruction class at decode
   always_comb begin
      state_d   = state_q;
      is_sw_d   = is_sw_q;
      is_ori_d  = is_ori_q;
      timeout_s = 1'b0;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready) begin
               state_d = ST_DECODE;
            end else if (expired_s) begin
               state_d   = ST_TRAP;
               timeout_s = 1'b1;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DECODE: begin
            is_sw_d  = (opcode == OP_SW);
            is_ori_d = (opcode == OP_ORI);
            case (opcode)
               OP_RTYPE:       state_d = funct_legal(funct) ? ST_R_EXEC : ST_TRAP;
               OP_LW, OP_SW:   state_d = ST_MEM_ADDR;
               OP_BEQ:         state_d = ST_BRANCH;
               OP_J:           state_d = ST_JUMP;
               OP_ADDI, OP_ORI: state_d = ST_I_EXEC;
               default:        state_d = ST_TRAP;
            endcase
         end
         ST_R_EXEC:   state_d = ST_R_WB;
         ST_R_WB:     state_d = ST_FETCH;
         ST_MEM_ADDR: state_d = is_sw_q ? ST_MEM_WRITE : ST_MEM_READ;
         ST_MEM_READ: begin
            if (mem_ready) begin
               state_d = ST_MEM_WB;
            end else if (expired_s) begin
               state_d   = ST_TRAP;
               timeout_s = 1'b1;
            end else begin
               state_d = ST_MEM_READ;
            end
         end
         ST_MEM_WB: state_d = ST_FETCH;
         ST_MEM_WRITE: begin
            if (mem_ready) begin
               state_d = ST_FETCH;
            end else if (expired_s) begin
               state_d   = ST_TRAP;
               timeout_s = 1'b1;
            end else begin
               state_d = ST_MEM_WRITE;
            end
         end
         ST_BRANCH: state_d = ST_FETCH;
         ST_JUMP:   state_d = ST_FETCH;
         ST_I_EXEC: state_d = ST_I_WB;
         ST_I_WB:   state_d = ST_FETCH;
         ST_TRAP:   state_d = ST_TRAP;
         default:   state_d = ST_TRAP;
      endcase
   end

   // Reset blanks every strobe immediately so no partial writeback completes.
   assign gate_s   = ~reset;
   assign retire_s = gate_s & (ctrl_q.retire | (ctrl_q.retire_rdy & mem_ready));

   // FSM state, strobes registered alongside it, sticky flags, retire count
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ctrl_q      <= ctrl_for_state(ST_IDLE, 1'b0);
         is_sw_q     <= 1'b0;
         is_ori_q    <= 1'b0;
         trap_q      <= 1'b0;
         bus_error_q <= 1'b0;
         count_q     <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         ctrl_q      <= ctrl_for_state(state_d, is_ori_d);
         is_sw_q     <= is_sw_d;
         is_ori_q    <= is_ori_d;
         trap_q      <= trap_q | (state_d == ST_TRAP);
         bus_error_q <= bus_error_q | timeout_s;
         count_q     <= retire_s ? count_q + CNT_W'(1) : count_q;
      end
   end

   assign irWrite     = gate_s & ctrl_q.ir_wr_rdy & mem_ready;
   assign pcWrite     = gate_s & (ctrl_q.pc_wr | (ctrl_q.pc_wr_rdy & mem_ready));
   assign pcWriteCond = gate_s & ctrl_q.pc_wr_cond;
   assign iorD        = gate_s & ctrl_q.ior_d;
   assign memRead     = gate_s & ctrl_q.mem_rd;
   assign memWrite    = gate_s & ctrl_q.mem_wr;
   assign memToReg    = gate_s & ctrl_q.mem_to_reg;
   assign regDst      = gate_s & ctrl_q.reg_dst;
   assign regWr       = gate_s & ctrl_q.reg_wr;
   assign aluSrcA     = gate_s & ctrl_q.alu_src_a;
   assign aluSrcB     = gate_s ? ctrl_q.alu_src_b : 2'b00;
   assign aluOp       = gate_s ? ctrl_q.alu_op    : 2'b00;
   assign pcSource    = gate_s ? ctrl_q.pc_source : 2'b00;
   assign retire      = retire_s;
   assign instr_count = count_q;
   assign trap        = trap_q;
   assign bus_error   = bus_error_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: instruction-level model
// expands each instruction into its expected per-cycle strobe vectors.
module tb_mips_multicycle_control;

   localparam int TO = 4;
   localparam int CW = 4;

   localparam int K_ILL = 0, K_R = 1, K_LW = 2, K_SW = 3, K_BEQ = 4,
                  K_J = 5, K_ADDI = 6, K_ORI = 7;

   logic          clock = 1'b0;
   logic          reset, zero, mem_ready;
   logic [5:0]    opcode, funct;
   logic          irWrite, pcWrite, pcWriteCond, iorD, memRead, memWrite;
   logic          memToReg, regDst, regWr, aluSrcA, retire, trap, bus_error;
   logic [1:0]    aluSrcB, aluOp, pcSource;
   logic [CW-1:0] instr_count;

   always #5 clock = ~clock;

   mips_multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
      .zero(zero), .mem_ready(mem_ready), .irWrite(irWrite),
      .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
      .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
      .regDst(regDst), .regWr(regWr), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
      .aluOp(aluOp), .pcSource(pcSource), .retire(retire),
      .instr_count(instr_count), .trap(trap), .bus_error(bus_error)
   );

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic        rdy;
      logic        rst;
      logic [16:0] exp;
      logic        etrap;
      logic        ebus;
   } vec_t;

   vec_t          q[$];
   int            n_checks = 0;
   int            n_err = 0;
   int            cyc = 0;
   logic          m_trap, m_bus;
   logic [CW-1:0] m_cnt;
   logic [5:0]    cur_op, cur_fn;
   logic          cur_z;

   // Vector order: irWrite pcWrite pcWriteCond iorD memRead memWrite memToReg
   // regDst regWr aluSrcA aluSrcB aluOp pcSource retire
   function automatic logic [16:0] ov(input logic irw, pcw, pcc, iord, mrd, mwr,
                                      m2r, rdst, rwr, asa, input logic [1:0] asb,
                                      aop, psrc, input logic ret);
      return {irw, pcw, pcc, iord, mrd, mwr, m2r, rdst, rwr, asa, asb, aop, psrc, ret};
   endfunction

   function automatic logic [16:0] v_fetch(input logic r);
      return ov(r, r, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
   endfunction
   function automatic logic [16:0] v_decode();
      return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
   endfunction
   function automatic logic [16:0] v_rexec();
      return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0);
   endfunction
   function automatic logic [16:0] v_rwb();
      return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
   endfunction
   function automatic logic [16:0] v_maddr();
      return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0);
   endfunction
   function automatic logic [16:0] v_mread();
      return ov(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
   endfunction
   function automatic logic [16:0] v_mwb();
      return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
   endfunction
   function automatic logic [16:0] v_mwrite(input logic r);
      return ov(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, r);
   endfunction
   function automatic logic [16:0] v_branch();
      return ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b1);
   endfunction
   function automatic logic [16:0] v_jump();
      return ov(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1);
   endfunction
   function automatic logic [16:0] v_iexec(input logic ori);
      return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10,
                ori ? 2'b11 : 2'b00, 2'b00, 1'b0);
   endfunction
   function automatic logic [16:0] v_iwb();
      return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
   endfunction

   function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'b000000: return (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                       6'b101010}) ? K_R : K_ILL;
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000100: return K_BEQ;
         6'b000010: return K_J;
         6'b001000: return K_ADDI;
         6'b001101: return K_ORI;
         default:   return K_ILL;
      endcase
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic rdy, input logic rst, input logic [16:0] e);
      vec_t v;
      v.op = cur_op; v.fn = cur_fn; v.z = cur_z; v.rdy = rdy; v.rst = rst;
      v.exp = e; v.etrap = m_trap; v.ebus = m_bus;
      q.push_back(v);
   endtask

   // Reset cycle (strobes blank, flags still old), then the single IDLE cycle.
   task automatic push_reset();
      push(rnd_bit(), 1'b1, 17'd0);
      m_trap = 1'b0;
      m_bus  = 1'b0;
      push(rnd_bit(), 1'b0, 17'd0);
   endtask

   task automatic push_trap(input int n, input logic bus);
      m_trap = 1'b1;
      m_bus  = m_bus | bus;
      repeat (n) push(rnd_bit(), 1'b0, 17'd0);
   endtask

   // One instruction: fw/mw are cycles with mem_ready low before the access
   // completes; TO or more means the access never completes.
   task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw, input logic rst_wb);
      int k;
      cur_op = op; cur_fn = fn; cur_z = z;
      k = kind_of(op, fn);
      if (fw >= TO) begin
         repeat (TO) push(1'b0, 1'b0, v_fetch(1'b0));
         push_trap(3, 1'b1);
         return;
      end
      repeat (fw) push(1'b0, 1'b0, v_fetch(1'b0));
      push(1'b1, 1'b0, v_fetch(1'b1));
      push(rnd_bit(), 1'b0, v_decode());
      case (k)
         K_R: begin
            push(rnd_bit(), 1'b0, v_rexec());
            push(rnd_bit(), 1'b0, v_rwb());
         end
         K_LW: begin
            push(rnd_bit(), 1'b0, v_maddr());
            if (mw >= TO) begin
               repeat (TO) push(1'b0, 1'b0, v_mread());
               push_trap(3, 1'b1);
               return;
            end
            repeat (mw) push(1'b0, 1'b0, v_mread());
            push(1'b1, 1'b0, v_mread());
            if (rst_wb) push_reset();
            else push(rnd_bit(), 1'b0, v_mwb());
         end
         K_SW: begin
            push(rnd_bit(), 1'b0, v_maddr());
            if (mw >= TO) begin
               repeat (TO) push(1'b0, 1'b0, v_mwrite(1'b0));
               push_trap(3, 1'b1);
               return;
            end
            repeat (mw) push(1'b0, 1'b0, v_mwrite(1'b0));
            push(1'b1, 1'b0, v_mwrite(1'b1));
         end
         K_BEQ:  push(rnd_bit(), 1'b0, v_branch());
         K_J:    push(rnd_bit(), 1'b0, v_jump());
         K_ADDI, K_ORI: begin
            push(rnd_bit(), 1'b0, v_iexec(k == K_ORI));
            push(rnd_bit(), 1'b0, v_iwb());
         end
         default: push_trap(20, 1'b0);
      endcase
   endtask

   task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, got, exp);
      end
   endtask

   task automatic run_queue();
      logic [16:0] got;
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clock);
         opcode = q[i].op; funct = q[i].fn; zero = q[i].z;
         mem_ready = q[i].rdy; reset = q[i].rst;
         #1;
         got = {irWrite, pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg,
                regDst, regWr, aluSrcA, aluSrcB, aluOp, pcSource, retire};
         check("strobes", got, q[i].exp);
         check("trap", {16'd0, trap}, {16'd0, q[i].etrap});
         check("bus_error", {16'd0, bus_error}, {16'd0, q[i].ebus});
         check("instr_count", 17'(instr_count), 17'(m_cnt));
         if (q[i].rst) m_cnt = '0;
         else if (q[i].exp[0]) m_cnt = m_cnt + 1'b1;
         cyc++;
      end
      q.delete();
   endtask

   logic [5:0] ops[7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b000010, 6'b001000, 6'b001101};
   logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   logic [5:0] r_op, r_fn;
   int         r_fw, r_mw;

   initial begin
      reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
      m_trap = 1'b0; m_bus = 1'b0; m_cnt = '0;
      cur_op = 6'd0; cur_fn = 6'd0; cur_z = 1'b0;
      repeat (2) @(posedge clock);

      // Directed table
      push_reset();
      push_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0);   // add, count -> 1
      push_instr(6'b100011, 6'b000000, 1'b0, 0, 3, 1'b0);   // lw, 3 wait cycles
      push_reset();
      push_instr(6'b000100, 6'b000000, 1'b1, 0, 0, 1'b0);   // beq taken
      push_instr(6'b000010, 6'b000000, 1'b0, 0, 0, 1'b0);   // j, count -> 2
      push_instr(6'b111111, 6'b000000, 1'b0, 0, 0, 1'b0);   // illegal opcode
      push_reset();
      push_instr(6'b000000, 6'b000000, 1'b0, 0, 0, 1'b0);   // illegal funct
      push_reset();
      push_instr(6'b000000, 6'b100000, 1'b0, TO, 0, 1'b0);  // fetch timeout
      push_reset();
      push_instr(6'b000000, 6'b100010, 1'b0, TO - 1, 0, 1'b0); // ready on last wait
      push_instr(6'b100011, 6'b000000, 1'b0, 0, TO, 1'b0);  // read timeout
      push_reset();
      push_instr(6'b101011, 6'b000000, 1'b0, 0, TO, 1'b0);  // write timeout
      push_reset();
      push_instr(6'b001000, 6'b000000, 1'b0, 0, 0, 1'b0);   // addi
      push_instr(6'b001101, 6'b000000, 1'b0, 0, 0, 1'b0);   // ori
      push_instr(6'b101011, 6'b000000, 1'b0, 1, TO - 1, 1'b0); // sw
      push_instr(6'b100011, 6'b000000, 1'b0, 0, 1, 1'b1);   // reset during MEM_WB
      push_instr(6'b000000, 6'b101010, 1'b0, 0, 0, 1'b0);   // slt after reset
      run_queue();

      // Randomized instruction stream
      for (int n = 0; n < 300; n++) begin
         r_op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                            : ops[$urandom_range(0, 6)];
         r_fn = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                            : fns[$urandom_range(0, 4)];
         r_fw = ($urandom_range(0, 14) == 0) ? TO : $urandom_range(0, TO - 1);
         r_mw = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
         push_instr(r_op, r_fn, rnd_bit(), r_fw, r_mw, $urandom_range(0, 19) == 0);
         if (m_trap) push_reset();
         run_queue();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
